// File: rtl/reorderbuffer.sv
// ---------------------------------------------------------------------------
// reorderbuffer
//   Circular reorder buffer sitting between the dispatcher/CDB and the
//   register file. Each issued instruction is given the tail tag, results
//   arriving on the CDB mark their entry ready, and entries retire strictly
//   in program order, at most one per cycle. A retirement produces a
//   register commit, a store-commit pulse, or (for a mispredicted branch) a
//   one-cycle rollback that also flushes the whole buffer.
//
// Ports
//   clk, rst, rdy            clock, synchronous active-low reset, global enable
//   issue_*                  allocation request from the dispatcher
//   issue_tag, rob_full      tag the next allocation receives / allocation refused
//   query_tag*/rdy*/val*     combinational operand lookup (two read ports)
//   cdb_*                    result broadcast (value, branch direction/target)
//   commit_*                 registered register-write / store retirement pulses
//   rollback, rollback_pc    registered mispredict pulse and redirect PC
// ---------------------------------------------------------------------------
module reorderbuffer #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [1:0]       issue_type,
  input  logic [4:0]       issue_rd,
  input  logic [31:0]      issue_pc,
  input  logic             issue_predTaken,
  input  logic             issue_ready,
  input  logic [31:0]      issue_val,
  output logic [TAG_W-1:0] issue_tag,
  output logic             rob_full,
  input  logic [TAG_W-1:0] query_tag1,
  input  logic [TAG_W-1:0] query_tag2,
  output logic             query_rdy1,
  output logic             query_rdy2,
  output logic [31:0]      query_val1,
  output logic [31:0]      query_val2,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_val,
  input  logic             cdb_taken,
  input  logic [31:0]      cdb_target,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_val,
  output logic             commit_store,
  output logic             rollback,
  output logic [31:0]      rollback_pc
);

  localparam logic [1:0]     TYPE_REG    = 2'd0;
  localparam logic [1:0]     TYPE_STORE  = 2'd1;
  localparam logic [1:0]     TYPE_BRANCH = 2'd2;
  localparam logic [1:0]     TYPE_RSVD   = 2'd3;
  localparam logic [TAG_W:0] FULL_COUNT  = (TAG_W+1)'(ROB_SIZE);

  // Per-entry control bits (reset) and payload (no reset; gated by valid)
  logic [ROB_SIZE-1:0] valid_q, valid_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;
  logic [ROB_SIZE-1:0] pred_q,  pred_d;
  logic [ROB_SIZE-1:0] taken_q, taken_d;
  logic [1:0]          type_q   [ROB_SIZE];
  logic [1:0]          type_d   [ROB_SIZE];
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [4:0]          rd_d     [ROB_SIZE];
  logic [31:0]         pc_q     [ROB_SIZE];
  logic [31:0]         pc_d     [ROB_SIZE];
  logic [31:0]         val_q    [ROB_SIZE];
  logic [31:0]         val_d    [ROB_SIZE];
  logic [31:0]         target_q [ROB_SIZE];
  logic [31:0]         target_d [ROB_SIZE];

  logic [TAG_W-1:0]    head_q, head_d;
  logic [TAG_W-1:0]    tail_q, tail_d;
  logic [TAG_W:0]      count_q, count_d;

  logic                commit_valid_q, commit_valid_d;
  logic [4:0]          commit_rd_q, commit_rd_d;
  logic [TAG_W-1:0]    commit_tag_q, commit_tag_d;
  logic [31:0]         commit_val_q, commit_val_d;
  logic                commit_store_q, commit_store_d;
  logic                rollback_q, rollback_d;
  logic [31:0]         rollback_pc_q, rollback_pc_d;

  logic                retire_s;
  logic                mispredict_s;
  logic                accept_s;

  // Full is judged from the occupancy count only; the rollback cycle also blocks issue
  assign rob_full  = (count_q == FULL_COUNT) || rollback_q;
  assign issue_tag = tail_q;

  assign query_rdy1 = valid_q[query_tag1] & ready_q[query_tag1];
  assign query_rdy2 = valid_q[query_tag2] & ready_q[query_tag2];
  assign query_val1 = query_rdy1 ? val_q[query_tag1] : 32'd0;
  assign query_val2 = query_rdy2 ? val_q[query_tag2] : 32'd0;

  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_tag   = commit_tag_q;
  assign commit_val   = commit_val_q;
  assign commit_store = commit_store_q;
  assign rollback     = rollback_q;
  assign rollback_pc  = rollback_pc_q;

  // Retirement decision uses registered ready bits, so a CDB write to the
  // head entry retires no earlier than the following edge.
  assign retire_s     = valid_q[head_q] & ready_q[head_q];
  assign mispredict_s = retire_s && (type_q[head_q] == TYPE_BRANCH) &&
                        (taken_q[head_q] != pred_q[head_q]);
  assign accept_s     = issue_valid & ~rob_full;

  // Next-state: CDB capture, in-order retirement, allocation and flush
  always_comb begin
    valid_d        = valid_q;
    ready_d        = ready_q;
    pred_d         = pred_q;
    taken_d        = taken_q;
    type_d         = type_q;
    rd_d           = rd_q;
    pc_d           = pc_q;
    val_d          = val_q;
    target_d       = target_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = commit_valid_q;
    commit_rd_d    = commit_rd_q;
    commit_tag_d   = commit_tag_q;
    commit_val_d   = commit_val_q;
    commit_store_d = commit_store_q;
    rollback_d     = rollback_q;
    rollback_pc_d  = rollback_pc_q;

    if (rdy) begin
      // Pulses last exactly one enabled cycle
      commit_valid_d = 1'b0;
      commit_store_d = 1'b0;
      rollback_d     = 1'b0;

      // Results for entries that are not allocated are dropped
      if (cdb_valid && valid_q[cdb_tag]) begin
        ready_d[cdb_tag] = 1'b1;
        val_d[cdb_tag]   = cdb_val;
        if (type_q[cdb_tag] == TYPE_BRANCH) begin
          taken_d[cdb_tag]  = cdb_taken;
          target_d[cdb_tag] = cdb_target;
        end else begin
          taken_d[cdb_tag]  = taken_q[cdb_tag];
        end
      end else begin
        ready_d = ready_d;
      end

      if (retire_s) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + TAG_W'(1);
        case (type_q[head_q])
          TYPE_STORE: begin
            commit_store_d = 1'b1;
            commit_tag_d   = head_q;
          end
          TYPE_BRANCH: begin
            if (mispredict_s) begin
              rollback_d    = 1'b1;
              rollback_pc_d = taken_q[head_q] ? target_q[head_q]
                                              : (pc_q[head_q] + 32'd4);
            end else begin
              rollback_d    = 1'b0;
            end
          end
          default: begin
            // rd==0 retires without touching the register file
            commit_valid_d = (rd_q[head_q] != 5'd0);
            commit_rd_d    = rd_q[head_q];
            commit_tag_d   = head_q;
            commit_val_d   = val_q[head_q];
          end
        endcase
      end else begin
        head_d = head_q;
      end

      // An issue in the flushing cycle would be wiped anyway, so it is dropped
      if (accept_s && !mispredict_s) begin
        valid_d[tail_q]  = 1'b1;
        ready_d[tail_q]  = issue_ready;
        type_d[tail_q]   = (issue_type == TYPE_RSVD) ? TYPE_REG : issue_type;
        rd_d[tail_q]     = issue_rd;
        pc_d[tail_q]     = issue_pc;
        pred_d[tail_q]   = issue_predTaken;
        val_d[tail_q]    = issue_val;
        taken_d[tail_q]  = 1'b0;
        target_d[tail_q] = 32'd0;
        tail_d           = tail_q + TAG_W'(1);
      end else begin
        tail_d = tail_q;
      end

      case ({accept_s && !mispredict_s, retire_s})
        2'b10:   count_d = count_q + (TAG_W+1)'(1);
        2'b01:   count_d = count_q - (TAG_W+1)'(1);
        default: count_d = count_q;
      endcase

      if (mispredict_s) begin
        valid_d = '0;
        ready_d = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        count_d = count_d;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Control state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q        <= '0;
      ready_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= 5'd0;
      commit_tag_q   <= '0;
      commit_val_q   <= 32'd0;
      commit_store_q <= 1'b0;
      rollback_q     <= 1'b0;
      rollback_pc_q  <= 32'd0;
    end else begin
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_tag_q   <= commit_tag_d;
      commit_val_q   <= commit_val_d;
      commit_store_q <= commit_store_d;
      rollback_q     <= rollback_d;
      rollback_pc_q  <= rollback_pc_d;
    end
  end

  // Entry payload registers; contents are only observed while valid is set
  always_ff @(posedge clk) begin
    pred_q   <= pred_d;
    taken_q  <= taken_d;
    type_q   <= type_d;
    rd_q     <= rd_d;
    pc_q     <= pc_d;
    val_q    <= val_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_reorderbuffer.sv
module tb_reorderbuffer;

  logic        clk, rst, rdy;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic        issue_predTaken, issue_ready;
  logic [31:0] issue_val;
  logic [3:0]  issue_tag;
  logic        rob_full;
  logic [3:0]  query_tag1, query_tag2;
  logic        query_rdy1, query_rdy2;
  logic [31:0] query_val1, query_val2;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        cdb_taken;
  logic [31:0] cdb_target;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_tag;
  logic [31:0] commit_val;
  logic        commit_store, rollback;
  logic [31:0] rollback_pc;

  reorderbuffer #(.ROB_SIZE(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_predTaken(issue_predTaken), .issue_ready(issue_ready),
    .issue_val(issue_val), .issue_tag(issue_tag), .rob_full(rob_full),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_rdy1(query_rdy1), .query_rdy2(query_rdy2),
    .query_val1(query_val1), .query_val2(query_val2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_val(commit_val), .commit_store(commit_store),
    .rollback(rollback), .rollback_pc(rollback_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: program-order queue ----------------
  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic        rdy;
    logic [31:0] val;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t        mq[$];
  int          m_head = 0;
  logic        exp_cv = 1'b0, exp_cs = 1'b0, exp_rb = 1'b0;
  logic [4:0]  exp_rd;
  logic [3:0]  exp_tag;
  logic [31:0] exp_val, exp_rbpc;
  int          sz_old, tail_old;
  bit          full_old, flush;
  ent_t        e, ne;

  function automatic logic [32:0] mquery(input logic [3:0] t);
    foreach (mq[i]) if (mq[i].tag == t && mq[i].rdy) return {1'b1, mq[i].val};
    return 33'd0;
  endfunction

  function automatic int m_tail();
    return (m_head + mq.size()) % 16;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_head = 0;
      exp_cv = 1'b0; exp_cs = 1'b0; exp_rb = 1'b0;
    end else if (rdy) begin
      sz_old   = mq.size();
      full_old = (sz_old == 16) || exp_rb;
      tail_old = (m_head + sz_old) % 16;
      exp_cv = 1'b0; exp_cs = 1'b0; exp_rb = 1'b0; flush = 1'b0;
      if (sz_old > 0 && mq[0].rdy) begin
        e = mq.pop_front();
        m_head = (m_head + 1) % 16;
        if (e.typ == 2'd1) begin
          exp_cs = 1'b1; exp_tag = e.tag;
        end else if (e.typ == 2'd2) begin
          if (e.taken != e.pred) begin
            flush = 1'b1; exp_rb = 1'b1;
            exp_rbpc = e.taken ? e.target : e.pc + 32'd4;
          end
        end else begin
          exp_cv = (e.rd != 5'd0);
          exp_rd = e.rd; exp_tag = e.tag; exp_val = e.val;
        end
      end
      if (cdb_valid) begin
        foreach (mq[i]) if (mq[i].tag == cdb_tag) begin
          ne = mq[i];
          ne.rdy = 1'b1; ne.val = cdb_val; ne.taken = cdb_taken; ne.target = cdb_target;
          mq[i] = ne;
        end
      end
      if (flush) begin
        mq.delete();
        m_head = 0;
      end else if (issue_valid) begin
        if (full_old) begin
          $display("note: issue while rob_full is illegal, ignored (t=%0t)", $time);
        end else begin
          ne.tag = 4'(tail_old); ne.typ = issue_type; ne.rd = issue_rd; ne.pc = issue_pc;
          ne.pred = issue_predTaken; ne.rdy = issue_ready; ne.val = issue_val;
          ne.taken = 1'b0; ne.target = 32'd0;
          mq.push_back(ne);
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  logic [32:0] q1, q2;
  always @(negedge clk) begin
    if (chk_en && rdy) begin
      q1 = mquery(query_tag1);
      q2 = mquery(query_tag2);
      chk("issue_tag", 32'(issue_tag), 32'(m_tail()));
      chk("rob_full", 32'(rob_full), 32'((mq.size() == 16) || exp_rb));
      chk("commit_valid", 32'(commit_valid), 32'(exp_cv));
      chk("commit_store", 32'(commit_store), 32'(exp_cs));
      chk("rollback", 32'(rollback), 32'(exp_rb));
      if (exp_cv) begin
        chk("commit_rd", 32'(commit_rd), 32'(exp_rd));
        chk("commit_tag", 32'(commit_tag), 32'(exp_tag));
        chk("commit_val", commit_val, exp_val);
      end
      if (exp_cs) chk("store_tag", 32'(commit_tag), 32'(exp_tag));
      if (exp_rb) chk("rollback_pc", rollback_pc, exp_rbpc);
      chk("query_rdy1", 32'(query_rdy1), 32'(q1[32]));
      chk("query_val1", query_val1, q1[31:0]);
      chk("query_rdy2", 32'(query_rdy2), 32'(q2[32]));
      chk("query_val2", query_val2, q2[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] r, input logic [31:0] pc,
                          input logic p, input logic rf, input logic [31:0] v);
    issue_valid = 1'b1; issue_type = t; issue_rd = r; issue_pc = pc;
    issue_predTaken = p; issue_ready = rf; issue_val = v;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_cdb(input logic [3:0] tg, input logic [31:0] v,
                        input logic tk, input logic [31:0] tgt);
    cdb_valid = 1'b1; cdb_tag = tg; cdb_val = v; cdb_taken = tk; cdb_target = tgt;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1;
    issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_pc = 32'd0;
    issue_predTaken = 1'b0; issue_ready = 1'b0; issue_val = 32'd0;
    query_tag1 = 4'd0; query_tag2 = 4'd0;
    cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_val = 32'd0; cdb_taken = 1'b0; cdb_target = 32'd0;

    // Reset
    tick(); tick();
    chk("rst_issue_tag", 32'(issue_tag), 32'd0);
    chk("rst_rob_full", 32'(rob_full), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_rollback", 32'(rollback), 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    // In-order commit
    do_issue(2'd0, 5'd5, 32'h0, 1'b0, 1'b0, 32'd0);
    do_issue(2'd0, 5'd6, 32'h4, 1'b0, 1'b0, 32'd0);
    do_cdb(4'd1, 32'h22, 1'b0, 32'd0);
    chk("order_no_early", 32'(commit_valid), 32'd0);
    do_cdb(4'd0, 32'h11, 1'b0, 32'd0);
    chk("order_cdb_latency", 32'(commit_valid), 32'd0);
    tick();
    chk("order0_valid", 32'(commit_valid), 32'd1);
    chk("order0_tag", 32'(commit_tag), 32'd0);
    chk("order0_rd", 32'(commit_rd), 32'd5);
    chk("order0_val", commit_val, 32'h11);
    tick();
    chk("order1_valid", 32'(commit_valid), 32'd1);
    chk("order1_tag", 32'(commit_tag), 32'd1);
    chk("order1_rd", 32'(commit_rd), 32'd6);
    chk("order1_val", commit_val, 32'h22);
    tick();
    chk("order_done", 32'(commit_valid), 32'd0);

    // Full and wrap
    do_reset();
    for (int i = 0; i < 16; i++) do_issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0, 1'b0, 32'd0);
    chk("full_flag", 32'(rob_full), 32'd1);
    chk("full_tail_wrapped", 32'(issue_tag), 32'd0);
    do_issue(2'd0, 5'd20, 32'h40, 1'b0, 1'b1, 32'hDEAD);
    chk("full_ignored_flag", 32'(rob_full), 32'd1);
    chk("full_ignored_tag", 32'(issue_tag), 32'd0);
    do_cdb(4'd0, 32'h55, 1'b0, 32'd0);
    tick();
    chk("wrap_commit_tag", 32'(commit_tag), 32'd0);
    chk("wrap_commit_val", commit_val, 32'h55);
    chk("wrap_not_full", 32'(rob_full), 32'd0);
    chk("wrap_next_tag", 32'(issue_tag), 32'd0);
    do_issue(2'd0, 5'd7, 32'h80, 1'b0, 1'b0, 32'd0);
    chk("wrap_tail", 32'(issue_tag), 32'd1);
    chk("wrap_full_again", 32'(rob_full), 32'd1);
    for (int t = 1; t < 16; t++) do_cdb(4'(t), 32'h100 + 32'(t), 1'b0, 32'd0);
    do_cdb(4'd0, 32'h200, 1'b0, 32'd0);
    tick(); tick(); tick();
    chk("drain_empty", 32'(rob_full), 32'd0);
    chk("drain_tag", 32'(issue_tag), 32'd1);

    // Mispredict, taken
    do_issue(2'd2, 5'd0, 32'h100, 1'b0, 1'b0, 32'd0);
    do_issue(2'd0, 5'd8, 32'h104, 1'b0, 1'b1, 32'h8);
    do_issue(2'd0, 5'd9, 32'h108, 1'b0, 1'b1, 32'h9);
    do_issue(2'd0, 5'd10, 32'h10C, 1'b0, 1'b1, 32'hA);
    do_cdb(4'd1, 32'd0, 1'b1, 32'h200);
    tick();
    chk("mis_rollback", 32'(rollback), 32'd1);
    chk("mis_pc", rollback_pc, 32'h200);
    chk("mis_tag0", 32'(issue_tag), 32'd0);
    chk("mis_full_blk", 32'(rob_full), 32'd1);
    do_issue(2'd0, 5'd11, 32'h110, 1'b0, 1'b1, 32'hB);
    chk("mis_pulse_end", 32'(rollback), 32'd0);
    chk("mis_refused", 32'(issue_tag), 32'd0);
    chk("mis_empty", 32'(rob_full), 32'd0);
    chk("mis_no_commit", 32'(commit_valid), 32'd0);
    tick();
    chk("mis_flushed", 32'(commit_valid), 32'd0);

    // Correctly predicted branch retires silently
    do_issue(2'd2, 5'd0, 32'h400, 1'b0, 1'b0, 32'd0);
    do_cdb(4'd0, 32'd0, 1'b0, 32'h500);
    tick();
    chk("okbr_rollback", 32'(rollback), 32'd0);
    chk("okbr_commit", 32'(commit_valid), 32'd0);
    chk("okbr_store", 32'(commit_store), 32'd0);
    chk("okbr_tag", 32'(issue_tag), 32'd1);

    // Mispredict, not taken -> pc + 4
    do_issue(2'd2, 5'd0, 32'h300, 1'b1, 1'b0, 32'd0);
    do_cdb(4'd1, 32'd0, 1'b0, 32'h999);
    tick();
    chk("nt_rollback", 32'(rollback), 32'd1);
    chk("nt_pc", rollback_pc, 32'h304);
    tick();

    // Store and rd0
    do_issue(2'd1, 5'd0, 32'h500, 1'b0, 1'b0, 32'd0);
    do_issue(2'd0, 5'd0, 32'h504, 1'b0, 1'b1, 32'h99);
    do_cdb(4'd0, 32'd0, 1'b0, 32'd0);
    tick();
    chk("st_pulse", 32'(commit_store), 32'd1);
    chk("st_tag", 32'(commit_tag), 32'd0);
    chk("st_no_reg", 32'(commit_valid), 32'd0);
    tick();
    chk("rd0_suppressed", 32'(commit_valid), 32'd0);
    chk("rd0_no_store", 32'(commit_store), 32'd0);
    chk("rd0_tag", 32'(issue_tag), 32'd2);

    // Query forwarding
    do_issue(2'd0, 5'd3, 32'h600, 1'b0, 1'b0, 32'd0);
    do_issue(2'd0, 5'd4, 32'h604, 1'b0, 1'b0, 32'd0);
    do_cdb(4'd3, 32'hABCD, 1'b0, 32'd0);
    query_tag1 = 4'd3; query_tag2 = 4'd2;
    #1;
    chk("q_rdy1", 32'(query_rdy1), 32'd1);
    chk("q_val1", query_val1, 32'hABCD);
    chk("q_rdy2_unready", 32'(query_rdy2), 32'd0);
    chk("q_val2_unready", query_val2, 32'd0);
    query_tag1 = 4'd5;
    #1;
    chk("q_invalid_rdy", 32'(query_rdy1), 32'd0);
    chk("q_invalid_val", query_val1, 32'd0);
    query_tag1 = 4'd2;

    // rdy stall: nothing changes, pulses hold
    do_cdb(4'd2, 32'h77, 1'b0, 32'd0);
    rdy = 1'b0;
    tick(); tick();
    chk("stall_no_commit", 32'(commit_valid), 32'd0);
    chk("stall_tag", 32'(issue_tag), 32'd4);
    chk("stall_q_ready", 32'(query_rdy1), 32'd1);
    rdy = 1'b1;
    tick();
    chk("resume_commit", 32'(commit_valid), 32'd1);
    chk("resume_rd", 32'(commit_rd), 32'd3);
    chk("resume_val", commit_val, 32'h77);
    rdy = 1'b0;
    tick();
    chk("hold_pulse", 32'(commit_valid), 32'd1);
    chk("hold_tag", 32'(commit_tag), 32'd2);
    rdy = 1'b1;
    tick();
    chk("next_commit_tag", 32'(commit_tag), 32'd3);
    chk("next_commit_val", commit_val, 32'hABCD);

    // Reserved type behaves as a register write
    do_issue(2'd3, 5'd12, 32'h700, 1'b0, 1'b1, 32'h33);
    tick();
    chk("rsvd_commit", 32'(commit_valid), 32'd1);
    chk("rsvd_rd", 32'(commit_rd), 32'd12);
    chk("rsvd_val", commit_val, 32'h33);
    chk("rsvd_tag", 32'(commit_tag), 32'd4);
    tick(); tick();
    chk("end_empty", 32'(rob_full), 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
